// File: rtl/sr_rx_if.sv
// rtl/sr_rx_if.sv - decoded-word output handshake between sr_rx and its consumer
//   data_out   : head-of-FIFO data word (master drives)
//   data_valid : FIFO non-empty (master drives)
//   data_ready : consumer accepts data_out this cycle (slave drives)
interface sr_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/sr_rx.sv
// rtl/sr_rx.sv - LED shift-register stream receiver: word reassembly, frame decode, output FIFO
//   clk_200   : 200 MHz logic clock
//   ar        : asynchronous reset, active-high
//   sr_clk_in : serial shift clock from the driver (asynchronous)
//   r_clk_in  : latch clock from the driver (asynchronous)
//   ser_in    : serial data from the driver, LSB first (asynchronous)
//   out_if    : data_out / data_valid / data_ready word stream
//   locked    : frame decoder aligned on a 0x00 reset word
//   frame_err : one-cycle pulse on a protocol violation or a short word
//   overflow  : sticky, a data word was dropped on a full FIFO
module sr_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic     clk_200,
  input  logic     ar,
  input  logic     sr_clk_in,
  input  logic     r_clk_in,
  input  logic     ser_in,
  sr_rx_if.master  out_if,
  output logic     locked,
  output logic     frame_err,
  output logic     overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, RST, MARK, POST} state_t;

  logic [SYNC_STAGES-1:0] sr_sync, r_sync, ser_sync;
  logic                   sr_prev, r_prev;
  logic                   sr_rise_q, r_rise_q, ser_q;

  logic [7:0] shreg, shreg_nx, word;
  logic [3:0] bit_cnt, cnt_nx;
  logic       word_evt, short_q;

  state_t     state;
  logic       push;
  logic [7:0] push_data;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic        pop, full, accept;

  // All three inputs share one synchronizer depth so their relative timing
  // survives; the rise pulses and data are re-registered together.
  always_ff @(posedge clk_200 or posedge ar) begin
    if (ar) begin
      sr_sync   <= '0;
      r_sync    <= '0;
      ser_sync  <= '0;
      sr_prev   <= 1'b0;
      r_prev    <= 1'b0;
      sr_rise_q <= 1'b0;
      r_rise_q  <= 1'b0;
      ser_q     <= 1'b0;
    end else begin
      sr_sync   <= {sr_sync[SYNC_STAGES-2:0], sr_clk_in};
      r_sync    <= {r_sync[SYNC_STAGES-2:0], r_clk_in};
      ser_sync  <= {ser_sync[SYNC_STAGES-2:0], ser_in};
      sr_prev   <= sr_sync[SYNC_STAGES-1];
      r_prev    <= r_sync[SYNC_STAGES-1];
      sr_rise_q <= sr_sync[SYNC_STAGES-1] & ~sr_prev;
      r_rise_q  <= r_sync[SYNC_STAGES-1] & ~r_prev;
      ser_q     <= ser_sync[SYNC_STAGES-1];
    end
  end

  // Shift view is computed first so a latch in the same cycle sees it.
  always_comb begin
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    if (sr_rise_q) begin
      shreg_nx = {ser_q, shreg[7:1]};
      if (bit_cnt != 4'd15)
        cnt_nx = bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_200 or posedge ar) begin
    if (ar) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      word_evt <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      shreg    <= shreg_nx;
      word_evt <= r_rise_q && (cnt_nx >= 4'd8);
      short_q  <= r_rise_q && (cnt_nx < 4'd8);
      bit_cnt  <= r_rise_q ? 4'd0 : cnt_nx;
      if (r_rise_q)
        word <= shreg_nx;
    end
  end

  always_ff @(posedge clk_200 or posedge ar) begin
    if (ar) begin
      state     <= HUNT;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push      <= 1'b0;
      frame_err <= short_q;
      if (word_evt) begin
        case (state)
          HUNT: if (word == 8'h00) begin
            state  <= RST;
            locked <= 1'b1;
          end
          RST: if (word == 8'hFF) begin
            state <= MARK;
          end else if (word != 8'h00) begin
            state     <= HUNT;
            frame_err <= 1'b1;
            locked    <= 1'b0;
          end
          MARK: begin
            push      <= 1'b1;
            push_data <= word;
            state     <= POST;
          end
          default: if (word == 8'h00) begin
            state <= RST;
          end else begin
            state     <= HUNT;
            frame_err <= 1'b1;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot a push at full needs.
  always_comb begin
    pop    = out_if.data_valid && out_if.data_ready;
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    accept = push && (!full || pop);
    wr_nx  = wr_ptr + {{AW{1'b0}}, accept};
    rd_nx  = rd_ptr + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk_200) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // data_valid/data_out are registered from the post-update pointers; a word
  // written into the next head slot is forwarded directly.
  always_ff @(posedge clk_200 or posedge ar) begin
    if (ar) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      out_if.data_valid <= 1'b0;
      out_if.data_out   <= '0;
      overflow          <= 1'b0;
    end else begin
      wr_ptr            <= wr_nx;
      rd_ptr            <= rd_nx;
      out_if.data_valid <= (wr_nx != rd_nx);
      if (wr_nx != rd_nx) begin
        if (accept && (wr_ptr[AW-1:0] == rd_nx[AW-1:0]))
          out_if.data_out <= push_data;
        else
          out_if.data_out <= mem[rd_nx[AW-1:0]];
      end
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_rx.sv
// tb/tb_sr_rx.sv - randomized self-checking bench for sr_rx against a word-level model
`timescale 1ns/100ps
module tb_sr_rx;
  localparam int S = 2;
  localparam int D = 4;

  logic clk_200   = 1'b0;
  logic ar        = 1'b1;
  logic sr_clk_in = 1'b0;
  logic r_clk_in  = 1'b0;
  logic ser_in    = 1'b0;
  logic locked, frame_err, overflow;

  sr_rx_if bus ();

  sr_rx #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
    .clk_200   (clk_200),
    .ar        (ar),
    .sr_clk_in (sr_clk_in),
    .r_clk_in  (r_clk_in),
    .ser_in    (ser_in),
    .out_if    (bus),
    .locked    (locked),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #2.5 clk_200 = ~clk_200;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0 low, 1 high, 2 random, 3 single pulse at pop_at
  int pop_at = -100;
  int last_e0 = 0;
  int dv_rise_cyc = -1;
  int err_pulses = 0;
  int err_cycles = 0;
  logic err_prev = 1'b0;
  logic dv_prev = 1'b0;

  // Reference model state: frame position (-1 unaligned, 0 after reset word,
  // 1 after marker, 2 after data), expected FIFO contents, error count, overflow.
  int pos = -1;
  logic [7:0] exp_q[$];
  int exp_err = 0;
  logic exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_200) cyc <= cyc + 1;

  always @(posedge clk_200) begin
    #2;
    case (ready_mode)
      0:       bus.data_ready = 1'b0;
      1:       bus.data_ready = 1'b1;
      2:       bus.data_ready = 1'($urandom_range(0, 1));
      default: bus.data_ready = (cyc == pop_at - 1);
    endcase
  end

  always @(negedge clk_200) begin
    if (frame_err) err_cycles++;
    if (frame_err && !err_prev) err_pulses++;
    err_prev = frame_err;
    if (bus.data_valid && !dv_prev) dv_rise_cyc = cyc;
    dv_prev = bus.data_valid;
    if (bus.data_valid && bus.data_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
      else check("data_out", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_200);
      #1;
    end
  endtask

  function automatic int phase();
    return int'($urandom_range(S + 1, S + 3));
  endfunction

  task automatic model_word(input logic [7:0] w, input int nbits);
    if (nbits < 8) begin
      exp_err++;
      return;
    end
    if (pos < 0) begin
      if (w == 8'h00) pos = 0;
    end else if (pos == 0) begin
      if (w == 8'hFF) pos = 1;
      else if (w != 8'h00) begin exp_err++; pos = -1; end
    end else if (pos == 1) begin
      if (ready_mode == 0 && exp_q.size() >= D) exp_ovf = 1'b1;
      else exp_q.push_back(w);
      pos = 2;
    end else begin
      if (w == 8'h00) pos = 0;
      else begin exp_err++; pos = -1; end
    end
  endtask

  task automatic mark_latch(input logic [7:0] w, input int nbits);
    last_e0 = cyc + 1;
    pop_at  = last_e0 + S + 3;
    model_word(w, nbits);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    bit comb;
    comb = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < nbits; i++) begin
      ser_in = w[i];
      sr_clk_in = 1'b0;
      tick(phase());
      sr_clk_in = 1'b1;
      if (comb && i == nbits - 1) begin
        r_clk_in = 1'b1;
        mark_latch(w, nbits);
      end
      tick(phase());
      sr_clk_in = 1'b0;
      r_clk_in  = 1'b0;
    end
    if (!comb) begin
      tick(phase());
      r_clk_in = 1'b1;
      mark_latch(w, nbits);
      tick(phase());
      r_clk_in = 1'b0;
    end
    tick(phase() + S + 4);
    check("locked", {31'd0, locked}, {31'd0, pos >= 0});
    check("err_pulses", err_pulses, exp_err);
    check("err_cycles", err_cycles, exp_err);
    check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_word(8'h00, 8);
    send_word(8'hFF, 8);
    send_word(d, 8);
  endtask

  task automatic drain();
    ready_mode = 1;
    tick(D + 6);
    check("fifo_drained", exp_q.size(), 0);
    check("valid_after_drain", {31'd0, bus.data_valid}, 0);
  endtask

  initial begin
    int kind;
    logic [7:0] d;

    tick(3);
    check("rst_valid", {31'd0, bus.data_valid}, 0);
    check("rst_data", {24'd0, bus.data_out}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    ar = 1'b0;
    tick(5);

    // Nominal frame with latency measurement
    ready_mode = 0;
    dv_rise_cyc = -1;
    send_frame(8'hA5);
    check("latency", dv_rise_cyc - last_e0, S + 3);
    check("nominal_data", {24'd0, bus.data_out}, 32'hA5);
    drain();

    // Marker-valued data words
    ready_mode = 0;
    send_frame(8'hFF);
    send_frame(8'h00);
    check("marker_head", {24'd0, bus.data_out}, 32'hFF);
    drain();

    // Protocol error then relock
    send_word(8'h00, 8);
    send_word(8'h3C, 8);
    send_frame(8'h11);
    drain();

    // Short word then a normal frame
    send_word(8'h96, 5);
    send_frame(8'hC3);
    drain();

    // Overflow, then a push coinciding with a pop at full
    ready_mode = 0;
    for (int i = 1; i <= D + 1; i++) send_frame(8'(i));
    check("ovf_head", {24'd0, bus.data_out}, 32'h01);
    send_word(8'h00, 8);
    send_word(8'hFF, 8);
    ready_mode = 3;
    send_word(8'h06, 8);
    ready_mode = 0;
    check("full_count", exp_q.size(), D);
    check("ovf_head2", {24'd0, bus.data_out}, 32'h02);
    drain();
    check("ovf_sticky", {31'd0, overflow}, 1);

    // Asynchronous reset mid-frame
    ready_mode = 0;
    send_frame(8'h77);
    send_word(8'h00, 8);
    send_word(8'hFF, 8);
    for (int i = 0; i < 4; i++) begin
      ser_in = 1'(i & 1);
      sr_clk_in = 1'b0;
      tick(phase());
      sr_clk_in = 1'b1;
      tick(phase());
      sr_clk_in = 1'b0;
    end
    check("pre_reset_valid", {31'd0, bus.data_valid}, {31'd0, exp_q.size() != 0});
    ser_in = 1'b0;
    ar = 1'b1;
    @(negedge clk_200);
    check("ar_valid", {31'd0, bus.data_valid}, 0);
    check("ar_data", {24'd0, bus.data_out}, 0);
    check("ar_locked", {31'd0, locked}, 0);
    check("ar_overflow", {31'd0, overflow}, 0);
    check("ar_frame_err", {31'd0, frame_err}, 0);
    exp_q.delete();
    pos = -1;
    exp_ovf = 1'b0;
    tick(3);
    ar = 1'b0;
    tick(4);
    ready_mode = 2;
    send_frame(8'h5A);
    drain();

    // Randomized traffic
    ready_mode = 2;
    for (int k = 0; k < 30; k++) begin
      kind = int'($urandom_range(0, 9));
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if (kind < 6) send_frame(d);
      else if (kind < 8) send_word(d, 8);
      else send_word(d, int'($urandom_range(1, 7)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
